// File: rtl/ctrl_pkg.sv
// Shared types for the execute-stage control slice.
//   ctrl_t          : decoded per-instruction control bundle carried from ID into EX
//   ex_state_t      : execute sequencer states
//   dispatch_state  : first EX state for an incoming instruction
package ctrl_pkg;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic [1:0] result_src;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [3:0] alu_control;
        logic       alu_op_and;
        logic       funct3_0;
        logic       out_issued;
        logic       in_issued;
        logic       fpu_dispatch;
        logic       fpu_reg_write;
        logic [1:0] write_src;
        logic       s_fpu;
    } ctrl_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC     = 3'd1,
        FPU_REQ  = 3'd2,
        FPU_WAIT = 3'd3,
        OUT_REQ  = 3'd4,
        IN_WAIT  = 3'd5
    } ex_state_t;

    // FPU work has priority over port I/O, and output over input, when a
    // bundle flags more than one multi-cycle operation.
    function automatic ex_state_t dispatch_state(input logic fpu_dispatch,
                                                 input logic out_issued,
                                                 input logic in_issued);
        if (fpu_dispatch) return FPU_REQ;
        if (out_issued)   return OUT_REQ;
        if (in_issued)    return IN_WAIT;
        return EXEC;
    endfunction

endpackage

// File: rtl/control_execute_stage_if.sv
// Bundle of the ID->EX handshake, the EX->MEM completion signals, the FPU and
// IO-port handshakes and the stall counter.
//   slave  : execute stage side (control_execute_stage)
//   master : environment side (decode, FPU, IO controller, MEM)
interface control_execute_stage_if #(
    parameter int CNT_W = 16
);
    import ctrl_pkg::*;

    logic             id_valid;
    ctrl_t            id_ctrl;
    logic             id_ready;
    logic             flush_ex;
    logic             ex_valid;
    ctrl_t            ex_ctrl;
    logic             ex_done;
    logic             fpu_req;
    logic             fpu_ack;
    logic             fpu_done;
    logic             out_req;
    logic             out_ack;
    logic             in_req;
    logic             in_valid;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  id_valid, id_ctrl, flush_ex, fpu_ack, fpu_done, out_ack, in_valid,
        output id_ready, ex_valid, ex_ctrl, ex_done, fpu_req, out_req, in_req, stall_cnt
    );

    modport master (
        output id_valid, id_ctrl, flush_ex, fpu_ack, fpu_done, out_ack, in_valid,
        input  id_ready, ex_valid, ex_ctrl, ex_done, fpu_req, out_req, in_req, stall_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with en_i high, holds at all-ones.
//   clk, rstn : clock, async active-low reset
//   en_i      : count enable
//   cnt_o     : current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/control_execute_stage.sv
// Execute-stage control: ID/EX control register plus sequencer for
// multi-cycle FPU and IO-port operations. Produces back-pressure to decode
// (id_ready), a one-cycle completion pulse toward MEM (ex_done) and a
// saturating count of decode stall cycles.
//   clk, rstn : core clock, async active-low reset
//   bus       : control_execute_stage_if.slave (ID handshake, EX outputs,
//               FPU / output-port / input-port handshakes, stall_cnt)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no live instruction in EX
// EXEC     | single-cycle op, completes this cycle
// FPU_REQ  | fpu_req high, waiting for fpu_ack
// FPU_WAIT | FPU accepted, waiting for fpu_done (may be killed by flush)
// OUT_REQ  | out_req high, completes on out_ack
// IN_WAIT  | in_req high, completes on in_valid
module control_execute_stage
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    control_execute_stage_if.slave bus
);

    ex_state_t state_q, state_d;
    logic      ex_valid_q, ex_valid_d;
    ctrl_t     ex_ctrl_q, ex_ctrl_d;
    logic      killed_q, killed_d;
    logic      fpu_req_q, fpu_req_d;
    logic      out_req_q, out_req_d;
    logic      in_req_q, in_req_d;

    logic      ex_done;
    logic      id_ready;
    logic      accept;
    ex_state_t follow_state;
    logic [CNT_W-1:0] stall_cnt;

    // Completion is decided before readiness so that a finishing instruction
    // can hand the slot to the next one in the same cycle. A flush cancels a
    // pure ALU op and a killed FPU op, but not an IO transfer whose side
    // effect already happened in this cycle.
    always_comb begin
        ex_done = 1'b0;
        case (state_q)
            EXEC:     ex_done = !bus.flush_ex;
            FPU_WAIT: ex_done = bus.fpu_done && !killed_q && !bus.flush_ex;
            OUT_REQ:  ex_done = bus.out_ack;
            IN_WAIT:  ex_done = bus.in_valid;
            default:  ex_done = 1'b0;
        endcase
        ex_done = ex_done && ex_valid_q;
    end

    assign id_ready = !bus.flush_ex && ((state_q == IDLE) || ex_done);
    assign accept   = bus.id_valid && id_ready;

    // Where EX goes after the current instruction leaves: the newly accepted
    // instruction's first state, or IDLE when nothing is taken.
    always_comb begin
        follow_state = IDLE;
        if (accept) begin
            follow_state = dispatch_state(bus.id_ctrl.fpu_dispatch,
                                          bus.id_ctrl.out_issued,
                                          bus.id_ctrl.in_issued);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                state_d = follow_state;
            end
            EXEC: begin
                state_d = follow_state;
            end
            FPU_REQ: begin
                if (bus.fpu_ack) begin
                    state_d = FPU_WAIT;
                end else if (bus.flush_ex) begin
                    state_d = IDLE;
                end
            end
            FPU_WAIT: begin
                // A killed op still has to drain the FPU before EX frees up.
                if (bus.fpu_done) begin
                    state_d = follow_state;
                end
            end
            OUT_REQ: begin
                if (bus.out_ack) begin
                    state_d = follow_state;
                end else if (bus.flush_ex) begin
                    state_d = IDLE;
                end
            end
            IN_WAIT: begin
                if (bus.in_valid) begin
                    state_d = follow_state;
                end else if (bus.flush_ex) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The kill mark only lives while the FPU op drains; any flush seen on the
    // way into or during FPU_WAIT sets it.
    always_comb begin
        ex_valid_d = (state_d != IDLE);
        ex_ctrl_d  = accept ? bus.id_ctrl : ex_ctrl_q;
        killed_d   = (state_d == FPU_WAIT) && (killed_q || bus.flush_ex);
        fpu_req_d  = (state_d == FPU_REQ);
        out_req_d  = (state_d == OUT_REQ);
        in_req_d   = (state_d == IN_WAIT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            killed_q   <= 1'b0;
            fpu_req_q  <= 1'b0;
            out_req_q  <= 1'b0;
            in_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            killed_q   <= killed_d;
            fpu_req_q  <= fpu_req_d;
            out_req_q  <= out_req_d;
            in_req_q   <= in_req_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .en_i  (bus.id_valid && !id_ready),
        .cnt_o (stall_cnt)
    );

    assign bus.id_ready  = id_ready;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_ctrl   = ex_ctrl_q;
    assign bus.ex_done   = ex_done;
    assign bus.fpu_req   = fpu_req_q;
    assign bus.out_req   = out_req_q;
    assign bus.in_req    = in_req_q;
    assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_control_execute_stage.sv
// Directed bench for control_execute_stage: ALU streaming, FPU handshake,
// IO flush cases, async reset and stall counter saturation (CNT_W=4).
module tb_control_execute_stage;
    import ctrl_pkg::*;

    localparam int CNT_W = 4;

    logic clk;
    logic rstn;
    int   errors = 0;
    int   checks = 0;
    int   n_req;

    control_execute_stage_if #(.CNT_W(CNT_W)) bus ();

    control_execute_stage #(
        .CNT_W (CNT_W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid = 1'b0;
        bus.id_ctrl  = '0;
        bus.flush_ex = 1'b0;
        bus.fpu_ack  = 1'b0;
        bus.fpu_done = 1'b0;
        bus.out_ack  = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
    endtask

    function automatic ctrl_t alu_op(input logic [3:0] code);
        ctrl_t c;
        c             = '0;
        c.reg_write   = 1'b1;
        c.alu_control = code;
        return c;
    endfunction

    function automatic ctrl_t fpu_op();
        ctrl_t c;
        c               = '0;
        c.fpu_dispatch  = 1'b1;
        c.fpu_reg_write = 1'b1;
        c.s_fpu         = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t out_op();
        ctrl_t c;
        c            = '0;
        c.out_issued = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t in_op();
        ctrl_t c;
        c           = '0;
        c.in_issued = 1'b1;
        c.reg_write = 1'b1;
        return c;
    endfunction

    initial begin
        rstn = 1'b0;
        clear_inputs();

        // reset state
        @(negedge clk);
        chk("rst_id_ready",  32'(bus.id_ready), 1);
        chk("rst_ex_valid",  32'(bus.ex_valid), 0);
        chk("rst_ex_ctrl",   32'(bus.ex_ctrl), 0);
        chk("rst_ex_done",   32'(bus.ex_done), 0);
        chk("rst_reqs",      32'({bus.fpu_req, bus.out_req, bus.in_req}), 0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 0);
        rstn = 1'b1;
        tick();

        // three back-to-back ALU ops, zero bubbles
        bus.id_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) bus.id_ctrl = alu_op(4'(i + 1));
            else       bus.id_valid = 1'b0;
            @(negedge clk);
            chk("alu_id_ready", 32'(bus.id_ready), 1);
            chk("alu_ex_done",  32'(bus.ex_done), (i > 0) ? 1 : 0);
            if (i > 0) chk("alu_ex_ctrl", 32'(bus.ex_ctrl), 32'(alu_op(4'(i))));
            tick();
        end
        @(negedge clk);
        chk("alu_ex_valid_end", 32'(bus.ex_valid), 0);
        chk("alu_ex_done_end",  32'(bus.ex_done), 0);
        chk("alu_stall_cnt",    32'(bus.stall_cnt), 0);
        tick();

        // FPU: ack at +2, done at +6, next op accepted in the done cycle
        do_reset();
        bus.id_valid = 1'b1;
        bus.id_ctrl  = fpu_op();
        @(negedge clk);
        chk("fpu_accept", 32'(bus.id_ready), 1);
        tick();
        bus.id_ctrl = alu_op(4'd5);
        n_req = 0;
        for (int c = 1; c <= 6; c++) begin
            bus.fpu_ack  = (c == 2);
            bus.fpu_done = (c == 6);
            @(negedge clk);
            if (bus.fpu_req) n_req++;
            chk("fpu_ex_done",  32'(bus.ex_done), (c == 6) ? 1 : 0);
            chk("fpu_id_ready", 32'(bus.id_ready), (c == 6) ? 1 : 0);
            tick();
        end
        bus.fpu_ack  = 1'b0;
        bus.fpu_done = 1'b0;
        bus.id_valid = 1'b0;
        chk("fpu_req_cycles", 32'(n_req), 2);
        @(negedge clk);
        chk("fpu_next_done",  32'(bus.ex_done), 1);
        chk("fpu_next_ctrl",  32'(bus.ex_ctrl), 32'(alu_op(4'd5)));
        chk("fpu_stall_cnt",  32'(bus.stall_cnt), 5);
        chk("fpu_req_off",    32'(bus.fpu_req), 0);
        tick();

        // OUT with immediate ack
        do_reset();
        bus.id_valid = 1'b1;
        bus.id_ctrl  = out_op();
        tick();
        bus.id_valid = 1'b0;
        bus.out_ack  = 1'b1;
        @(negedge clk);
        chk("out_req_on",  32'(bus.out_req), 1);
        chk("out_ex_done", 32'(bus.ex_done), 1);
        tick();
        bus.out_ack = 1'b0;
        @(negedge clk);
        chk("out_req_off",  32'(bus.out_req), 0);
        chk("out_ex_valid", 32'(bus.ex_valid), 0);
        tick();

        // OUT flushed while waiting for ack
        do_reset();
        bus.id_valid = 1'b1;
        bus.id_ctrl  = out_op();
        tick();
        bus.id_ctrl = alu_op(4'd7);
        @(negedge clk);
        chk("oflush_req_w1",   32'(bus.out_req), 1);
        chk("oflush_ready_w1", 32'(bus.id_ready), 0);
        tick();
        bus.flush_ex = 1'b1;
        @(negedge clk);
        chk("oflush_done_w2",  32'(bus.ex_done), 0);
        chk("oflush_ready_w2", 32'(bus.id_ready), 0);
        tick();
        bus.flush_ex = 1'b0;
        @(negedge clk);
        chk("oflush_req_off",  32'(bus.out_req), 0);
        chk("oflush_ex_valid", 32'(bus.ex_valid), 0);
        chk("oflush_done_off", 32'(bus.ex_done), 0);
        chk("oflush_accept",   32'(bus.id_ready), 1);
        tick();
        bus.id_valid = 1'b0;
        @(negedge clk);
        chk("oflush_next_ctrl", 32'(bus.ex_ctrl), 32'(alu_op(4'd7)));
        chk("oflush_next_done", 32'(bus.ex_done), 1);
        tick();

        // FPU killed in FPU_WAIT, drains until fpu_done
        do_reset();
        bus.id_valid = 1'b1;
        bus.id_ctrl  = fpu_op();
        tick();
        bus.id_ctrl = alu_op(4'd9);
        bus.fpu_ack = 1'b1;
        @(negedge clk);
        chk("kill_req", 32'(bus.fpu_req), 1);
        tick();
        bus.fpu_ack  = 1'b0;
        bus.flush_ex = 1'b1;
        @(negedge clk);
        chk("kill_req_off", 32'(bus.fpu_req), 0);
        tick();
        bus.flush_ex = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            bus.fpu_done = (c == 6);
            @(negedge clk);
            chk("kill_id_ready", 32'(bus.id_ready), 0);
            chk("kill_ex_done",  32'(bus.ex_done), 0);
            tick();
        end
        bus.fpu_done = 1'b0;
        @(negedge clk);
        chk("kill_ex_valid", 32'(bus.ex_valid), 0);
        chk("kill_done_off", 32'(bus.ex_done), 0);
        chk("kill_ready",    32'(bus.id_ready), 1);
        tick();
        bus.id_valid = 1'b0;
        @(negedge clk);
        chk("kill_next_ctrl", 32'(bus.ex_ctrl), 32'(alu_op(4'd9)));
        chk("kill_next_done", 32'(bus.ex_done), 1);
        chk("kill_stall_cnt", 32'(bus.stall_cnt), 6);
        tick();

        // IN completes in the same cycle as a flush; incoming op is dropped
        do_reset();
        bus.id_valid = 1'b1;
        bus.id_ctrl  = in_op();
        tick();
        bus.id_ctrl = alu_op(4'd11);
        @(negedge clk);
        chk("in_req_on", 32'(bus.in_req), 1);
        tick();
        bus.in_valid = 1'b1;
        bus.flush_ex = 1'b1;
        @(negedge clk);
        chk("in_flush_done",  32'(bus.ex_done), 1);
        chk("in_flush_ready", 32'(bus.id_ready), 0);
        tick();
        bus.in_valid = 1'b0;
        bus.flush_ex = 1'b0;
        bus.id_valid = 1'b0;
        @(negedge clk);
        chk("in_ex_valid", 32'(bus.ex_valid), 0);
        chk("in_req_off",  32'(bus.in_req), 0);
        chk("in_done_off", 32'(bus.ex_done), 0);
        tick();

        // async reset in the middle of FPU_REQ
        do_reset();
        bus.id_valid = 1'b1;
        bus.id_ctrl  = fpu_op();
        tick();
        bus.id_valid = 1'b0;
        @(negedge clk);
        chk("arst_pre_req", 32'(bus.fpu_req), 1);
        rstn = 1'b0;
        #1;
        chk("arst_fpu_req",  32'(bus.fpu_req), 0);
        chk("arst_ex_valid", 32'(bus.ex_valid), 0);
        chk("arst_ex_ctrl",  32'(bus.ex_ctrl), 0);
        chk("arst_ex_done",  32'(bus.ex_done), 0);
        chk("arst_id_ready", 32'(bus.id_ready), 1);
        #1;
        rstn = 1'b1;
        tick();

        // long stall behind an unacked FPU op: counter saturates at 15
        bus.id_valid = 1'b1;
        bus.id_ctrl  = fpu_op();
        tick();
        bus.id_ctrl = alu_op(4'd3);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("sat_stall_cnt", 32'(bus.stall_cnt), (k - 1 > 15) ? 15 : k - 1);
            tick();
        end
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
